fb_scanout: RTL and testbench
=============================

# fb_scanout

Video scanout engine on the read side of the 1-bpp framebuffer that the GPU command executor writes. It generates raster timing (hsync, vsync, data enable) and reads one pixel per active position from the front framebuffer. It delivers that pixel aligned with the sync signals to the display encoder. It also owns double-buffer flipping: the producer requests a swap, and the flip happens only at the start of vertical blanking.

## Interface

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line
- VER_ACTIVE_PIXELS, 480, visible lines per frame
- HOR_FRONT_PORCH, 16; HOR_SYNC, 96; HOR_BACK_PORCH, 48: horizontal blanking, in pixels
- VER_FRONT_PORCH, 10; VER_SYNC, 2; VER_BACK_PORCH, 33: vertical blanking, in lines
- SYNC_ACTIVE, 0, asserted level of hsync/vsync
- RD_LATENCY, 1, framebuffer read latency in ce-qualified cycles (1..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel clock enable; all state advances only when ce=1
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  21  linear pixel index within the front buffer, v*HOR_ACTIVE_PIXELS+h
- rd_data  in  1  pixel returned RD_LATENCY ce-cycles after rd_en
- front_buf  out  1  selects which buffer is being scanned; the write side uses ~front_buf
- swap_req  in  1  level: producer has finished the back buffer
- swap_ack  out  1  one ce-cycle pulse when front_buf toggles
- vblank_start  out  1  one ce-cycle pulse at the start of the first blanking line
- hsync, vsync  out  1  sync outputs
- de  out  1  data enable
- pixel  out  1  pixel value; 0 whenever de=0

## Operation

- H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH; V_TOTAL is defined likewise.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance on every ce=1 cycle.
  - h wraps to 0 and increments v.
  - v wraps to 0 after V_TOTAL-1.
- Active region: h < HOR_ACTIVE_PIXELS and v < VER_ACTIVE_PIXELS.
- Sync assertion:
  - hsync is asserted for HOR_ACTIVE_PIXELS+HOR_FRONT_PORCH ≤ h < that + HOR_SYNC.
  - vsync uses the analogous range on v.
- Read issue: in the active region, rd_en=1 and rd_addr = v*HOR_ACTIVE_PIXELS+h. Otherwise rd_en=0 and rd_addr holds its last value.
  - rd_addr is generated by a running counter, not a multiplier.
  - The counter resets to 0 at h=0, v=0.
- Swap: at the counter position h=0, v=VER_ACTIVE_PIXELS:
  - vblank_start pulses.
  - If swap_req=1, front_buf toggles and swap_ack pulses in the same cycle.
  - swap_req is sampled only at this point. One swap per frame at most.
- Width rules:
  - h and v are 11 bits.
  - rd_addr is 21 bits; the design requires HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS ≤ 2^21.

## Timing

- All outputs are registered.
- rd_en/rd_addr appear 1 ce-cycle after the counter position.
- hsync, vsync and de are delayed so that they align with pixel. pixel appears RD_LATENCY+1 ce-cycles after the corresponding rd_en.
- vblank_start, swap_ack and front_buf toggling are undelayed, aligned with rd_en timing. The buffer select therefore never changes while a read of the active frame is in flight.
- ce=0: counters, the pipeline and all outputs hold. The framebuffer must hold rd_data across ce=0 cycles.
- Reset values, applied immediately on rst_n=0 without waiting for a clock edge:
  - h=v=0, rd_addr=0
  - rd_en=0, de=0, pixel=0
  - hsync=vsync=~SYNC_ACTIVE
  - front_buf=0, swap_ack=0, vblank_start=0
  - pipeline cleared
- After rst_n rises, the first ce=1 cycle processes position h=0, v=0.
- Reset mid-frame: the frame is aborted and the next frame starts at 0,0. A pending swap is discarded.

## Test plan

Bench parameters: HA=8, VA=4, HFP=1, HS=2, HBP=1, VFP=1, VS=1, VBP=1, RD_LATENCY=1, giving H_TOTAL=12 and V_TOTAL=7.

- Reset release, ce=1 constant -> rd_en=1 with rd_addr=0 on the 1st edge after release; de=1 and pixel=mem[0] on the 3rd edge; hsync/vsync idle high.
- Address sequence over one frame -> rd_addr runs 0..31 with exactly 32 rd_en pulses and no rd_en during h=8..11 or v=4..6; pixel matches a memory checkerboard pattern.
- Sync shape -> hsync low for exactly 2 ce-cycles per line, 1 cycle after de falls; vsync low for exactly 12 ce-cycles per frame, during line v=5; de high 8 cycles per line on 4 lines.
- swap_req held 1 -> front_buf toggles once per frame, coincident with vblank_start and a 1-cycle swap_ack. swap_req pulsed only during v=1 -> no toggle.
- ce asserted 1 of every 4 clocks -> output sequence per ce-cycle is identical to the ce=1 run; outputs stable on ce=0 clocks.
- rst_n dropped at h=5, v=2 while swap_req=1 -> all outputs take reset values with no clock edge; after release, rd_addr restarts at 0 and front_buf=0.

Source files
------------

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - raster timing, 1-bpp framebuffer scanout and vblank double-buffer flip
module fb_scanout #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int HOR_FRONT_PORCH   = 16,
    parameter int HOR_SYNC          = 96,
    parameter int HOR_BACK_PORCH    = 48,
    parameter int VER_FRONT_PORCH   = 10,
    parameter int VER_SYNC          = 2,
    parameter int VER_BACK_PORCH    = 33,
    parameter bit SYNC_ACTIVE       = 1'b0,
    parameter int RD_LATENCY        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic        rd_en,
    output logic [20:0] rd_addr,
    input  logic        rd_data,
    output logic        front_buf,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        vblank_start,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pixel
);
    localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;

    localparam logic [10:0] H_ACT      = 11'(HOR_ACTIVE_PIXELS);
    localparam logic [10:0] H_SYNC_BEG = 11'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [10:0] H_SYNC_END = 11'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT      = 11'(VER_ACTIVE_PIXELS);
    localparam logic [10:0] V_SYNC_BEG = 11'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [10:0] V_SYNC_END = 11'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

    // Stage 0 is the rd_en stage; the last stage lines up with pixel.
    localparam int DEPTH = RD_LATENCY + 2;

    logic [10:0]      h_q, h_d;
    logic [10:0]      v_q, v_d;
    logic [20:0]      addr_cnt_q, addr_cnt_d;
    logic [20:0]      rd_addr_q, rd_addr_d;
    logic             front_buf_q, front_buf_d;
    logic             swap_ack_q, swap_ack_d;
    logic             vblank_start_q, vblank_start_d;
    logic             pixel_q, pixel_d;
    logic [DEPTH-1:0] de_pipe_q, de_pipe_d;
    logic [DEPTH-1:0] hs_pipe_q, hs_pipe_d;
    logic [DEPTH-1:0] vs_pipe_q, vs_pipe_d;

    logic active;
    logic hs_lvl;
    logic vs_lvl;

    always_comb begin
        active = (h_q < H_ACT) && (v_q < V_ACT);
        hs_lvl = ((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_lvl = ((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

        h_d            = h_q;
        v_d            = v_q;
        addr_cnt_d     = addr_cnt_q;
        rd_addr_d      = rd_addr_q;
        front_buf_d    = front_buf_q;
        swap_ack_d     = swap_ack_q;
        vblank_start_d = vblank_start_q;
        pixel_d        = pixel_q;
        de_pipe_d      = de_pipe_q;
        hs_pipe_d      = hs_pipe_q;
        vs_pipe_d      = vs_pipe_q;

        if (ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end

            // Running address counter restarts at the top-left pixel of each frame.
            if (active) begin
                rd_addr_d  = ((h_q == '0) && (v_q == '0)) ? 21'd0 : addr_cnt_q;
                addr_cnt_d = rd_addr_d + 21'd1;
            end

            vblank_start_d = (h_q == '0) && (v_q == V_ACT);
            swap_ack_d     = vblank_start_d && swap_req;
            front_buf_d    = front_buf_q ^ swap_ack_d;

            pixel_d   = de_pipe_q[DEPTH-2] & rd_data;
            de_pipe_d = {de_pipe_q[DEPTH-2:0], active};
            hs_pipe_d = {hs_pipe_q[DEPTH-2:0], hs_lvl};
            vs_pipe_d = {vs_pipe_q[DEPTH-2:0], vs_lvl};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q            <= '0;
            v_q            <= '0;
            addr_cnt_q     <= '0;
            rd_addr_q      <= '0;
            front_buf_q    <= 1'b0;
            swap_ack_q     <= 1'b0;
            vblank_start_q <= 1'b0;
            pixel_q        <= 1'b0;
            de_pipe_q      <= '0;
            hs_pipe_q      <= {DEPTH{~SYNC_ACTIVE}};
            vs_pipe_q      <= {DEPTH{~SYNC_ACTIVE}};
        end else begin
            h_q            <= h_d;
            v_q            <= v_d;
            addr_cnt_q     <= addr_cnt_d;
            rd_addr_q      <= rd_addr_d;
            front_buf_q    <= front_buf_d;
            swap_ack_q     <= swap_ack_d;
            vblank_start_q <= vblank_start_d;
            pixel_q        <= pixel_d;
            de_pipe_q      <= de_pipe_d;
            hs_pipe_q      <= hs_pipe_d;
            vs_pipe_q      <= vs_pipe_d;
        end
    end

    assign rd_en        = de_pipe_q[0];
    assign rd_addr      = rd_addr_q;
    assign front_buf    = front_buf_q;
    assign swap_ack     = swap_ack_q;
    assign vblank_start = vblank_start_q;
    assign de           = de_pipe_q[DEPTH-1];
    assign hsync        = hs_pipe_q[DEPTH-1];
    assign vsync        = vs_pipe_q[DEPTH-1];
    assign pixel        = pixel_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - scoreboard bench for fb_scanout on an 8x4 raster (12x7 total)
module tb_fb_scanout;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0;
    logic        rd_en;
    logic [20:0] rd_addr;
    logic        rd_data = 1'b0;
    logic        front_buf;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        vblank_start;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        pixel;

    fb_scanout #(
        .HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(4),
        .HOR_FRONT_PORCH(1), .HOR_SYNC(2), .HOR_BACK_PORCH(1),
        .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1),
        .SYNC_ACTIVE(1'b0), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .front_buf(front_buf), .swap_req(swap_req), .swap_ack(swap_ack),
        .vblank_start(vblank_start), .hsync(hsync), .vsync(vsync),
        .de(de), .pixel(pixel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd_en;
        logic [20:0] rd_addr;
        logic        de;
        logic        hs;
        logic        vs;
        logic        pix;
        logic        vb;
        logic        ack;
        logic        fb;
    } out_t;

    localparam out_t RST_VAL = {1'b0, 21'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [3:0] DL_RST = 4'b0110;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    int          mh, mv;
    logic        m_fb;
    logic [20:0] m_addr;
    logic [3:0]  dl0, dl1;

    // Checkerboard in buffer 0, inverted checkerboard in buffer 1.
    function automatic logic pat(input logic b, input int a);
        return (((a % 8) + (a / 8) + int'(b)) % 2) == 0;
    endfunction

    function automatic out_t dut_out();
        return {rd_en, rd_addr, de, hsync, vsync, pixel, vblank_start, swap_ack, front_buf};
    endfunction

    always @(posedge clk) if (ce && rd_en) rd_data <= pat(front_buf, int'(rd_addr));

    task automatic step(input logic ce_val);
        out_t       e;
        logic       act, vb, ack;
        logic [3:0] cur;
        ce = ce_val;
        @(posedge clk);
        if (ce_val) begin
            act = (mh < 8) && (mv < 4);
            cur = {act, ((mh >= 9) && (mh < 11)) ? 1'b0 : 1'b1, (mv == 5) ? 1'b0 : 1'b1,
                   act ? pat(m_fb, mv * 8 + mh) : 1'b0};
            if (act) m_addr = 21'(mv * 8 + mh);
            vb  = (mh == 0) && (mv == 4);
            ack = vb && swap_req;
            if (ack) m_fb = ~m_fb;
            e = {act, m_addr, dl1, vb, ack, m_fb};
            dl1 = dl0;
            dl0 = cur;
            if (mh == 11) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; m_fb = 1'b0; m_addr = '0;
        dl0 = DL_RST; dl1 = DL_RST;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ce = 1'b1; swap_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        out_t e, o;
        #1;
        rst_n = 1'b0;
        #1;
        o = dut_out();
        checks++;
        if (o !== RST_VAL) begin errors++; $display("FAIL reset_async obs=%h exp=%h", o, RST_VAL); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_seq i=%0d obs=%h exp=%h", i, o, e); end
            if (i == 0) begin
                checks++;
                if ({rd_en, rd_addr, hsync, vsync} !== {1'b1, 21'd0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL first_read obs=%b/%0d/%b%b exp=1/0/11", rd_en, rd_addr, hsync, vsync);
                end
            end
            if (i == 2) begin
                checks++;
                if ({de, pixel} !== 2'b11) begin
                    errors++;
                    $display("FAIL first_pixel obs=%b%b exp=11", de, pixel);
                end
            end
        end
    endtask

    task automatic test_frame();
        out_t e, o;
        int   n_rd, nxt;
        do_reset();
        n_rd = 0; nxt = 0;
        for (int i = 0; i < 84; i++) begin
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL frame_seq i=%0d obs=%h exp=%h", i, o, e); end
            if (rd_en === 1'b1) begin
                checks++;
                if (rd_addr !== 21'(nxt)) begin
                    errors++;
                    $display("FAIL frame_addr obs=%0d exp=%0d", rd_addr, nxt);
                end
                n_rd++;
                nxt++;
            end
        end
        checks++;
        if (n_rd != 32) begin errors++; $display("FAIL frame_rd_count obs=%0d exp=32", n_rd); end
    endtask

    task automatic test_sync();
        out_t e, o;
        int   n_hs, n_vs, n_de;
        do_reset();
        n_hs = 0; n_vs = 0; n_de = 0;
        for (int i = 0; i < 86; i++) begin
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sync_seq i=%0d obs=%h exp=%h", i, o, e); end
            if (i >= 2) begin
                if (hsync === 1'b0) n_hs++;
                if (vsync === 1'b0) n_vs++;
                if (de === 1'b1) n_de++;
            end
        end
        checks++;
        if (n_hs != 14) begin errors++; $display("FAIL hsync_low_count obs=%0d exp=14", n_hs); end
        checks++;
        if (n_vs != 12) begin errors++; $display("FAIL vsync_low_count obs=%0d exp=12", n_vs); end
        checks++;
        if (n_de != 32) begin errors++; $display("FAIL de_count obs=%0d exp=32", n_de); end
    endtask

    task automatic test_swap();
        out_t e, o;
        int   n_tog, n_ack;
        logic prev_fb;
        do_reset();
        swap_req = 1'b1;
        n_tog = 0; n_ack = 0; prev_fb = 1'b0;
        for (int i = 0; i < 252; i++) begin
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL swap_seq i=%0d obs=%h exp=%h", i, o, e); end
            if (front_buf !== prev_fb) n_tog++;
            prev_fb = front_buf;
            if (swap_ack === 1'b1) begin
                n_ack++;
                checks++;
                if (vblank_start !== 1'b1) begin
                    errors++;
                    $display("FAIL swap_vblank_align obs=%b exp=1", vblank_start);
                end
            end
        end
        checks++;
        if (n_tog != 3) begin errors++; $display("FAIL swap_toggles obs=%0d exp=3", n_tog); end
        checks++;
        if (n_ack != 3) begin errors++; $display("FAIL swap_acks obs=%0d exp=3", n_ack); end
        n_tog = 0;
        for (int i = 0; i < 168; i++) begin
            swap_req = (mv == 1);
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL noswap_seq i=%0d obs=%h exp=%h", i, o, e); end
            if (front_buf !== prev_fb) n_tog++;
            prev_fb = front_buf;
        end
        swap_req = 1'b0;
        checks++;
        if (n_tog != 0) begin errors++; $display("FAIL noswap_toggles obs=%0d exp=0", n_tog); end
    endtask

    task automatic test_ce();
        out_t e, o, last_e;
        do_reset();
        last_e = RST_VAL;
        for (int k = 0; k < 336; k++) begin
            step((k % 4) == 0);
            o = dut_out();
            if ((k % 4) == 0) begin
                e = exp_q.pop_front();
                last_e = e;
                checks++;
                if (o !== e) begin errors++; $display("FAIL ce_seq k=%0d obs=%h exp=%h", k, o, e); end
            end else begin
                checks++;
                if (o !== last_e) begin errors++; $display("FAIL ce_hold k=%0d obs=%h exp=%h", k, o, last_e); end
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_t e, o;
        do_reset();
        swap_req = 1'b1;
        for (int i = 0; i < 84 + 29; i++) begin
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL midrst_pre i=%0d obs=%h exp=%h", i, o, e); end
        end
        checks++;
        if ({mh, mv, front_buf} !== {32'd5, 32'd2, 1'b1}) begin
            errors++;
            $display("FAIL midrst_position obs=%0d,%0d fb=%b exp=5,2 fb=1", mh, mv, front_buf);
        end
        rst_n = 1'b0;
        #2;
        o = dut_out();
        checks++;
        if (o !== RST_VAL) begin errors++; $display("FAIL midrst_async obs=%h exp=%h", o, RST_VAL); end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            e = exp_q.pop_front();
            o = dut_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL midrst_post i=%0d obs=%h exp=%h", i, o, e); end
            if (i == 0) begin
                checks++;
                if ({rd_en, rd_addr, front_buf} !== {1'b1, 21'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL midrst_restart obs=%b/%0d/%b exp=1/0/0", rd_en, rd_addr, front_buf);
                end
            end
        end
        swap_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_sync();
        test_swap();
        test_ce();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
